// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the FP execute-stage control blocks.
package fp_ctrl_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam int FREG_W      = 5;
  localparam int MUL_TIMEOUT = 64;
endpackage

// File: rtl/fp_hazard_cmp.sv
// RAW/WAW match of one instruction's FP operands against a pending destination.
module fp_hazard_cmp
  import fp_ctrl_pkg::*;
(
  input  logic [FREG_W-1:0] i_pdest,
  input  logic [FREG_W-1:0] i_src_a,
  input  logic              i_use_a,
  input  logic [FREG_W-1:0] i_src_b,
  input  logic              i_use_b,
  input  logic [FREG_W-1:0] i_dest,
  input  logic              i_wr,
  output logic              o_hit
);
  assign o_hit = (i_use_a && (i_src_a == i_pdest)) ||
                 (i_use_b && (i_src_b == i_pdest)) ||
                 (i_wr    && (i_dest  == i_pdest));
endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback control for the multi-cycle FP multiplier: one outstanding
// destination, EX hazard stalls, and arbitration of the single FP write port.
module mul_issue_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int TIMEOUT = MUL_TIMEOUT,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mul_in,
  input  logic [FREG_W-1:0] fDestReg_in,
  input  logic              FPRegWrite_in,
  input  logic [FREG_W-1:0] fSrcA_in,
  input  logic [FREG_W-1:0] fSrcB_in,
  input  logic              fSrcA_use,
  input  logic              fSrcB_use,
  input  logic              mul_done,
  output logic              mul_start,
  output logic              stall_out,
  output logic              wb_mul,
  output logic              FPRegWrite_out,
  output logic [FREG_W-1:0] fDestReg_out,
  output logic              busy,
  output logic              err_timeout
);
  state_t            r_state;
  logic [FREG_W-1:0] r_pdest;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  logic w_run, w_wr, w_hit, w_haz, w_pc, w_stall, w_cmpl;

  assign w_run = (r_state == RUN) && !reset;
  assign w_wr  = FPRegWrite_in && !mul_in;

  fp_hazard_cmp u_cmp (
    .i_pdest (r_pdest),
    .i_src_a (fSrcA_in),
    .i_use_a (fSrcA_use),
    .i_src_b (fSrcB_in),
    .i_use_b (fSrcB_use),
    .i_dest  (fDestReg_in),
    .i_wr    (w_wr),
    .o_hit   (w_hit)
  );

  // No result bypass: hazards hold through the completion cycle itself.
  assign w_haz   = w_run && (w_hit || mul_in);
  assign w_pc    = w_run && mul_done && w_wr;
  assign w_stall = w_haz || w_pc;
  assign w_cmpl  = w_run && mul_done;

  assign mul_start      = !reset && (r_state == IDLE) && mul_in;
  assign stall_out      = w_stall;
  assign wb_mul         = w_cmpl;
  assign FPRegWrite_out = !reset && (w_cmpl || (w_wr && !w_stall));
  assign fDestReg_out   = reset  ? '0 : (w_cmpl ? r_pdest : fDestReg_in);
  assign busy           = w_run;
  assign err_timeout    = r_err && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pdest <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (mul_in) begin
          r_pdest <= fDestReg_in;
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (mul_done) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Multiplier never answered: drop the op without writing.
            r_state <= IDLE;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_mul_issue_ctrl;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       mul_in, FPRegWrite_in, fSrcA_use, fSrcB_use, mul_done;
  logic [4:0] fDestReg_in, fSrcA_in, fSrcB_in;
  logic       mul_start, stall_out, wb_mul, FPRegWrite_out, busy, err_timeout;
  logic [4:0] fDestReg_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mul_in(mul_in), .fDestReg_in(fDestReg_in),
    .FPRegWrite_in(FPRegWrite_in), .fSrcA_in(fSrcA_in), .fSrcB_in(fSrcB_in),
    .fSrcA_use(fSrcA_use), .fSrcB_use(fSrcB_use), .mul_done(mul_done),
    .mul_start(mul_start), .stall_out(stall_out), .wb_mul(wb_mul),
    .FPRegWrite_out(FPRegWrite_out), .fDestReg_out(fDestReg_out),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic drv(input logic m, input logic [4:0] d, input logic fw,
                     input logic [4:0] sa, input logic ua,
                     input logic [4:0] sb, input logic ub, input logic dn);
    mul_in = m; fDestReg_in = d; FPRegWrite_in = fw;
    fSrcA_in = sa; fSrcA_use = ua; fSrcB_in = sb; fSrcB_use = ub; mul_done = dn;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(1, 5'd9, 1, 0, 1, 0, 1, 1);
    total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", mul_start); end
    total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_out); end
    total++; if (FPRegWrite_out !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", FPRegWrite_out); end
    total++; if (fDestReg_out !== 5'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", fDestReg_out); end
    total++; if ({busy, wb_mul, err_timeout} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {busy, wb_mul, err_timeout}); end
    tick(); reset = 1'b0;
    idle();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_issue_wb();
    drv(1, 5'd7, 0, 0, 0, 0, 0, 0);
    total++; if (mul_start !== 1'b1) begin bad++; $display("FAIL iss_start got=%b exp=1", mul_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL iss_busy0 got=%b exp=0", busy); end
    tick();
    for (int i = 1; i <= 3; i++) begin
      idle();
      total++; if ({busy, mul_start, FPRegWrite_out} !== 3'b100) begin bad++; $display("FAIL run%0d busy/start/wr got=%b exp=100", i, {busy, mul_start, FPRegWrite_out}); end
      tick();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    total++; if ({wb_mul, FPRegWrite_out} !== 2'b11) begin bad++; $display("FAIL wb_en got=%b exp=11", {wb_mul, FPRegWrite_out}); end
    total++; if (fDestReg_out !== 5'd7) begin bad++; $display("FAIL wb_addr got=%0d exp=7", fDestReg_out); end
    tick();
    idle();
    total++; if ({busy, FPRegWrite_out, wb_mul} !== 3'b000) begin bad++; $display("FAIL wb_after got=%b exp=000", {busy, FPRegWrite_out, wb_mul}); end
  endtask

  task automatic test_raw(input logic [4:0] src, input logic exp);
    drv(1, 5'd7, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, 0, src, 1, 0, 0, 0);
      total++; if (stall_out !== exp) begin bad++; $display("FAIL raw_src%0d_c%0d got=%b exp=%b", src, i, stall_out, exp); end
      tick();
    end
    drv(0, 0, 0, src, 1, 0, 0, 1);
    total++; if (stall_out !== exp) begin bad++; $display("FAIL raw_src%0d_done got=%b exp=%b", src, stall_out, exp); end
    tick();
    drv(0, 0, 0, src, 1, 0, 0, 0);
    total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL raw_src%0d_release got=%b exp=0", src, stall_out); end
    tick();
  endtask

  task automatic test_port_conflict();
    drv(1, 5'd7, 0, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    drv(0, 5'd3, 1, 0, 0, 0, 0, 1);
    total++; if ({FPRegWrite_out, wb_mul, stall_out} !== 3'b111) begin bad++; $display("FAIL pc_d wr/wb/stall got=%b exp=111", {FPRegWrite_out, wb_mul, stall_out}); end
    total++; if (fDestReg_out !== 5'd7) begin bad++; $display("FAIL pc_d_addr got=%0d exp=7", fDestReg_out); end
    tick();
    drv(0, 5'd3, 1, 0, 0, 0, 0, 0);
    total++; if ({FPRegWrite_out, wb_mul, stall_out, busy} !== 4'b1000) begin bad++; $display("FAIL pc_d1 wr/wb/stall/busy got=%b exp=1000", {FPRegWrite_out, wb_mul, stall_out, busy}); end
    total++; if (fDestReg_out !== 5'd3) begin bad++; $display("FAIL pc_d1_addr got=%0d exp=3", fDestReg_out); end
    tick();
  endtask

  task automatic test_back_to_back();
    drv(1, 5'd7, 0, 0, 0, 0, 0, 0); tick();
    drv(1, 5'd9, 0, 0, 0, 0, 0, 0);
    total++; if ({stall_out, mul_start} !== 2'b10) begin bad++; $display("FAIL b2b_struct got=%b exp=10", {stall_out, mul_start}); end
    tick();
    drv(0, 5'd7, 1, 0, 0, 0, 0, 0);
    total++; if ({stall_out, FPRegWrite_out} !== 2'b10) begin bad++; $display("FAIL b2b_waw got=%b exp=10", {stall_out, FPRegWrite_out}); end
    tick();
    drv(1, 5'd9, 0, 0, 0, 0, 0, 1);
    total++; if ({stall_out, mul_start, FPRegWrite_out} !== 3'b101) begin bad++; $display("FAIL b2b_d got=%b exp=101", {stall_out, mul_start, FPRegWrite_out}); end
    total++; if (fDestReg_out !== 5'd7) begin bad++; $display("FAIL b2b_d_addr got=%0d exp=7", fDestReg_out); end
    tick();
    drv(1, 5'd9, 0, 0, 0, 0, 0, 0);
    total++; if ({stall_out, mul_start} !== 2'b01) begin bad++; $display("FAIL b2b_d1 got=%b exp=01", {stall_out, mul_start}); end
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    total++; if (fDestReg_out !== 5'd9) begin bad++; $display("FAIL b2b_2nd_addr got=%0d exp=9", fDestReg_out); end
    tick();
  endtask

  task automatic test_timeout();
    drv(1, 5'd5, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < TO; i++) begin
      idle();
      total++; if ({busy, FPRegWrite_out} !== 2'b10) begin bad++; $display("FAIL to_run%0d busy/wr got=%b exp=10", i, {busy, FPRegWrite_out}); end
      tick();
    end
    idle();
    total++; if ({busy, err_timeout} !== 2'b01) begin bad++; $display("FAIL to_end busy/err got=%b exp=01", {busy, err_timeout}); end
    drv(0, 0, 0, 0, 0, 0, 0, 1); tick();
    idle();
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
    do_reset();
    idle();
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b exp=0", err_timeout); end
  endtask

  task automatic test_reset_mid_run();
    drv(1, 5'd7, 0, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    reset = 1'b1;
    drv(0, 5'd3, 1, 5'd7, 1, 0, 0, 1);
    total++; if ({FPRegWrite_out, wb_mul, busy, stall_out} !== 4'b0000) begin bad++; $display("FAIL rmr_outs got=%b exp=0000", {FPRegWrite_out, wb_mul, busy, stall_out}); end
    total++; if (fDestReg_out !== 5'd0) begin bad++; $display("FAIL rmr_addr got=%0d exp=0", fDestReg_out); end
    tick(); reset = 1'b0;
    drv(0, 0, 0, 5'd7, 1, 0, 0, 1);
    total++; if ({busy, stall_out, FPRegWrite_out} !== 3'b000) begin bad++; $display("FAIL rmr_after got=%b exp=000", {busy, stall_out, FPRegWrite_out}); end
    tick();
  endtask

  // Reference: at most one pending mul with a destination and an age in RUN cycles.
  task automatic test_random();
    bit         pend = 0, err = 0;
    logic [4:0] pd = 0;
    int         age = 0;
    logic       r, m, fw, ua, ub, dn, wr, hz, pc, st, cm;
    logic       e_start, e_stall, e_wb, e_wr, e_busy, e_err;
    logic [4:0] d, sa, sb, e_addr;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom % 60) == 0;
      m  = ($urandom % 5) == 0;
      d  = 5'($urandom % 4);
      fw = $urandom % 2;
      sa = 5'($urandom % 4); ua = $urandom % 2;
      sb = 5'($urandom % 4); ub = $urandom % 2;
      dn = ($urandom % 5) == 0;
      reset = r;
      drv(m, d, fw, sa, ua, sb, ub, dn);
      wr = fw && !m;
      if (r) begin
        {e_start, e_stall, e_wb, e_wr, e_busy, e_err} = '0;
        e_addr = 0;
      end else begin
        hz = pend && ((ua && sa == pd) || (ub && sb == pd) || (wr && d == pd) || m);
        pc = pend && dn && wr;
        st = hz || pc;
        cm = pend && dn;
        e_start = !pend && m;
        e_stall = st;
        e_wb    = cm;
        e_wr    = cm || (wr && !st);
        e_addr  = cm ? pd : d;
        e_busy  = pend;
        e_err   = err;
      end
      total++; if (mul_start !== e_start) begin bad++; $display("FAIL rnd%0d start got=%b exp=%b", n, mul_start, e_start); end
      total++; if (stall_out !== e_stall) begin bad++; $display("FAIL rnd%0d stall got=%b exp=%b", n, stall_out, e_stall); end
      total++; if (wb_mul !== e_wb) begin bad++; $display("FAIL rnd%0d wb_mul got=%b exp=%b", n, wb_mul, e_wb); end
      total++; if (FPRegWrite_out !== e_wr) begin bad++; $display("FAIL rnd%0d wr got=%b exp=%b", n, FPRegWrite_out, e_wr); end
      total++; if (e_wr && fDestReg_out !== e_addr) begin bad++; $display("FAIL rnd%0d addr got=%0d exp=%0d", n, fDestReg_out, e_addr); end
      total++; if ({busy, err_timeout} !== {e_busy, e_err}) begin bad++; $display("FAIL rnd%0d busy/err got=%b exp=%b", n, {busy, err_timeout}, {e_busy, e_err}); end
      if (r) begin
        pend = 0; err = 0; pd = 0;
      end else if (pend) begin
        age++;
        if (dn) pend = 0;
        else if (age == TO) begin pend = 0; err = 1; end
      end else if (m) begin
        pend = 1; pd = d; age = 0;
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    test_reset();
    test_issue_wb();
    test_raw(5'd7, 1'b1);
    test_raw(5'd8, 1'b0);
    test_port_conflict();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
